// File: rtl/pet_needs_if.sv
// Pulse inputs and stat outputs exchanged between the input front-end and the need engine.
interface pet_needs_if #(
  parameter int NUM_NEEDS = 4,
  parameter int VAL_W     = 3,
  parameter int SEL_W     = 3
);
  logic [NUM_NEEDS-1:0]       care_pulse;
  logic                       heal_pulse;
  logic                       test_toggle;
  logic                       test_next;
  logic                       test_inc;
  logic                       test_dec;
  logic [NUM_NEEDS*VAL_W-1:0] need_values;
  logic [VAL_W-1:0]           health_value;
  logic [NUM_NEEDS-1:0]       critical_mask;
  logic                       sec_tick;
  logic                       test_mode;
  logic [SEL_W-1:0]           test_sel;
  logic                       alive;

  modport master (
    output care_pulse, heal_pulse, test_toggle, test_next, test_inc, test_dec,
    input  need_values, health_value, critical_mask, sec_tick, test_mode, test_sel, alive
  );

  modport slave (
    input  care_pulse, heal_pulse, test_toggle, test_next, test_inc, test_dec,
    output need_values, health_value, critical_mask, sec_tick, test_mode, test_sel, alive
  );
endinterface

// File: rtl/pet_needs_engine.sv
// Need/health engine: per-channel decay, shared health penalised by critical needs,
// with RUN/TEST/DEAD modes.
module pet_needs_engine #(
  parameter int NUM_NEEDS      = 4,
  parameter int VAL_W          = 3,
  parameter int VAL_MAX        = 5,
  parameter int VAL_INIT       = 5,
  parameter int TICK_DIV       = 50000000,
  parameter int DECAY_PERIOD   = 30,
  parameter int CRIT_LEVEL     = 2,
  parameter int PENALTY_PERIOD = 10,
  parameter int SEL_W          = 3
) (
  input  logic       clk,
  input  logic       rst,
  pet_needs_if.slave bus
);
  localparam int W    = VAL_W + 1;
  localparam int PS_W = $clog2(TICK_DIV + 1);
  localparam int DC_W = $clog2(DECAY_PERIOD + 1);
  localparam int PC_W = $clog2(PENALTY_PERIOD + 1);

  localparam logic [W-1:0]     MAX_W      = W'(VAL_MAX);
  localparam logic [W-1:0]     ONE_W      = W'(1);
  localparam logic [VAL_W-1:0] INIT_V     = VAL_W'(VAL_INIT);
  localparam logic [VAL_W-1:0] CRIT_V     = VAL_W'(CRIT_LEVEL);
  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(TICK_DIV - 1);
  localparam logic [DC_W-1:0]  DC_LAST    = DC_W'(DECAY_PERIOD - 1);
  localparam logic [PC_W-1:0]  PC_LAST    = PC_W'(PENALTY_PERIOD - 1);
  localparam logic [SEL_W-1:0] SEL_HEALTH = SEL_W'(NUM_NEEDS);

  // S_RUN: normal decay/care | S_TEST: manual edit, counters frozen | S_DEAD: terminal until rst
  typedef enum logic [1:0] {S_RUN, S_TEST, S_DEAD} mode_t;

  mode_t                mode_q;
  logic [VAL_W-1:0]     need_q      [NUM_NEEDS];
  logic [VAL_W-1:0]     run_need_d  [NUM_NEEDS];
  logic [VAL_W-1:0]     test_need_d [NUM_NEEDS];
  logic [DC_W-1:0]      dcnt_q      [NUM_NEEDS];
  logic [DC_W-1:0]      dcnt_d      [NUM_NEEDS];
  logic [VAL_W-1:0]     health_q, run_health_d, test_health_d;
  logic [PC_W-1:0]      pcnt_q, pcnt_d;
  logic [PS_W-1:0]      ps_q;
  logic                 sec_tick_q, test_mode_q, alive_q;
  logic [SEL_W-1:0]     test_sel_q;
  logic [NUM_NEEDS-1:0] crit;
  logic [NUM_NEEDS*VAL_W-1:0] need_flat;
  logic                 penalty;
  logic [W-1:0]         nv, hv, tv;

  always_comb begin
    crit      = '0;
    need_flat = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      crit[i] = (need_q[i] <= CRIT_V);
      need_flat[i*VAL_W +: VAL_W] = need_q[i];
    end
  end

  // RUN-mode need update: care wins over a coincident decay expiry
  always_comb begin
    nv = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      run_need_d[i] = need_q[i];
      dcnt_d[i]     = dcnt_q[i];
      nv            = {1'b0, need_q[i]};
      if (bus.care_pulse[i]) begin
        nv            = (nv + ONE_W > MAX_W) ? MAX_W : nv + ONE_W;
        run_need_d[i] = nv[VAL_W-1:0];
        dcnt_d[i]     = '0;
      end else if (sec_tick_q) begin
        if (dcnt_q[i] == DC_LAST) begin
          dcnt_d[i] = '0;
          if (nv != '0) nv = nv - ONE_W;
          run_need_d[i] = nv[VAL_W-1:0];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DC_W'(1);
        end
      end
    end
  end

  always_comb begin
    penalty = 1'b0;
    pcnt_d  = pcnt_q;
    hv      = {1'b0, health_q};
    if (sec_tick_q && (crit != '0)) begin
      if (pcnt_q == PC_LAST) begin
        pcnt_d  = '0;
        penalty = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PC_W'(1);
      end
    end
    if (bus.heal_pulse && !penalty)
      hv = (hv + ONE_W > MAX_W) ? MAX_W : hv + ONE_W;
    else if (penalty && !bus.heal_pulse && hv != '0)
      hv = hv - ONE_W;
    run_health_d = hv[VAL_W-1:0];
  end

  // TEST-mode edit of the selected stat; health floors at 1 so TEST cannot kill
  always_comb begin
    tv            = '0;
    test_health_d = health_q;
    for (int i = 0; i < NUM_NEEDS; i++) test_need_d[i] = need_q[i];
    if (bus.test_inc ^ bus.test_dec) begin
      if (test_sel_q == SEL_HEALTH) begin
        tv = {1'b0, health_q};
        if (bus.test_inc) tv = (tv + ONE_W > MAX_W) ? MAX_W : tv + ONE_W;
        else if (tv > ONE_W) tv = tv - ONE_W;
        test_health_d = tv[VAL_W-1:0];
      end else begin
        for (int i = 0; i < NUM_NEEDS; i++) begin
          if (test_sel_q == SEL_W'(i)) begin
            tv = {1'b0, need_q[i]};
            if (bus.test_inc) tv = (tv + ONE_W > MAX_W) ? MAX_W : tv + ONE_W;
            else if (tv != '0) tv = tv - ONE_W;
            test_need_d[i] = tv[VAL_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= S_RUN;
      ps_q        <= '0;
      sec_tick_q  <= 1'b0;
      test_mode_q <= 1'b0;
      test_sel_q  <= '0;
      alive_q     <= 1'b1;
      health_q    <= INIT_V;
      pcnt_q      <= '0;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        need_q[i] <= INIT_V;
        dcnt_q[i] <= DC_W'((i * DECAY_PERIOD) / NUM_NEEDS);
      end
    end else begin
      sec_tick_q <= (ps_q == PS_LAST);
      ps_q       <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
      case (mode_q)
        S_RUN: begin
          dcnt_q   <= dcnt_d;
          pcnt_q   <= pcnt_d;
          health_q <= run_health_d;
          for (int i = 0; i < NUM_NEEDS; i++)
            need_q[i] <= (run_health_d == '0) ? '0 : run_need_d[i];
          if (run_health_d == '0) begin
            mode_q  <= S_DEAD;
            alive_q <= 1'b0;
          end else if (bus.test_toggle) begin
            mode_q      <= S_TEST;
            test_mode_q <= 1'b1;
            test_sel_q  <= '0;
          end
        end
        S_TEST: begin
          if (bus.test_toggle) begin
            mode_q      <= S_RUN;
            test_mode_q <= 1'b0;
          end else begin
            need_q   <= test_need_d;
            health_q <= test_health_d;
            if (bus.test_next)
              test_sel_q <= (test_sel_q == SEL_HEALTH) ? '0 : test_sel_q + SEL_W'(1);
          end
        end
        S_DEAD: begin
          health_q <= '0;
          for (int i = 0; i < NUM_NEEDS; i++) need_q[i] <= '0;
        end
        default: mode_q <= S_DEAD;
      endcase
    end
  end

  assign bus.need_values   = need_flat;
  assign bus.health_value  = health_q;
  assign bus.critical_mask = crit;
  assign bus.sec_tick      = sec_tick_q;
  assign bus.test_mode     = test_mode_q;
  assign bus.test_sel      = test_sel_q;
  assign bus.alive         = alive_q;
endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed bench for pet_needs_engine with a short prescaler and decay/penalty periods.
module tb_pet_needs_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  always #5 clk = ~clk;

  pet_needs_if #(.NUM_NEEDS(4), .VAL_W(3), .SEL_W(3)) bus ();

  pet_needs_engine #(
    .NUM_NEEDS(4), .VAL_W(3), .VAL_MAX(5), .VAL_INIT(5), .TICK_DIV(4),
    .DECAY_PERIOD(3), .CRIT_LEVEL(2), .PENALTY_PERIOD(2), .SEL_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected needs per tick after reset, hex digits n3 n2 n1 n0
  logic [15:0] s1_need [17] = '{16'h4555, 16'h4455, 16'h4444, 16'h3444, 16'h3344, 16'h3333,
                                16'h2333, 16'h2233, 16'h2222, 16'h1222, 16'h1122, 16'h1111,
                                16'h0111, 16'h0011, 16'h0000, 16'h0000, 16'h0000};
  int s1_health [17] = '{5, 5, 5, 5, 5, 5, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};

  function automatic logic [11:0] pack(input logic [15:0] d);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = d[i*4 +: 3];
    return r;
  endfunction

  function automatic logic [3:0] critm(input logic [15:0] d);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (d[i*4 +: 4] <= 4'd2);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    step(1);
    bus.care_pulse  = '0;
    bus.heal_pulse  = 1'b0;
    bus.test_toggle = 1'b0;
    bus.test_next   = 1'b0;
    bus.test_inc    = 1'b0;
    bus.test_dec    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic wait_sec(output int cnt);
    cnt = 0;
    while (bus.sec_tick !== 1'b1 && cnt < 50) begin
      step(1);
      cnt++;
    end
    chk("sec_tick_seen", bus.sec_tick, 1);
  endtask

  // returns once the effects of the next sec_tick are visible
  task automatic tick(output int cnt);
    wait_sec(cnt);
    step(1);
    chk("sec_tick_width", bus.sec_tick, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.care_pulse  = '0;
    bus.heal_pulse  = 1'b0;
    bus.test_toggle = 1'b0;
    bus.test_next   = 1'b0;
    bus.test_inc    = 1'b0;
    bus.test_dec    = 1'b0;
    step(2);
    rst = 1'b0;

    chk("rst_needs", bus.need_values, pack(16'h5555));
    chk("rst_health", bus.health_value, 5);
    chk("rst_alive", bus.alive, 1);
    chk("rst_test_mode", bus.test_mode, 0);
    chk("rst_test_sel", bus.test_sel, 0);
    chk("rst_crit", bus.critical_mask, 0);
    chk("rst_sec_tick", bus.sec_tick, 0);

    // idle decay, staggered channels, penalties, then death
    for (int t = 0; t < 17; t++) begin
      tick(n);
      chk("s1_period", n, (t == 0) ? 4 : 3);
      chk("s1_needs", bus.need_values, pack(s1_need[t]));
      chk("s1_health", bus.health_value, s1_health[t]);
      chk("s1_alive", bus.alive, (t == 16) ? 0 : 1);
      chk("s1_crit", bus.critical_mask, critm(s1_need[t]));
    end
    bus.care_pulse = 4'hF; cyc();
    bus.heal_pulse = 1'b1; cyc();
    bus.test_toggle = 1'b1; cyc();
    tick(n);
    chk("dead_needs", bus.need_values, 0);
    chk("dead_health", bus.health_value, 0);
    chk("dead_alive", bus.alive, 0);
    chk("dead_test_mode", bus.test_mode, 0);
    chk("dead_crit", bus.critical_mask, 4'hF);
    do_reset();
    chk("revive_needs", bus.need_values, pack(16'h5555));
    chk("revive_health", bus.health_value, 5);
    chk("revive_alive", bus.alive, 1);

    // need0 held critical, penalty every 2 ticks, heal on the penalty cycle
    bus.test_toggle = 1'b1; cyc();
    chk("s2_test_mode", bus.test_mode, 1);
    chk("s2_test_sel", bus.test_sel, 0);
    for (int k = 0; k < 3; k++) begin bus.test_dec = 1'b1; cyc(); end
    chk("s2_need0", bus.need_values[2:0], 2);
    chk("s2_crit", bus.critical_mask, 4'b0001);
    bus.test_toggle = 1'b1; cyc();
    chk("s2_run_mode", bus.test_mode, 0);
    tick(n); chk("s2_health_r1", bus.health_value, 5);
    tick(n); chk("s2_health_r2", bus.health_value, 4);
    tick(n); chk("s2_health_r3", bus.health_value, 4);
    tick(n); chk("s2_health_r4", bus.health_value, 3);
    tick(n); chk("s2_health_r5", bus.health_value, 3);
    wait_sec(n);
    bus.heal_pulse = 1'b1; cyc();
    chk("s2_heal_on_penalty", bus.health_value, 3);
    tick(n); chk("s2_health_r7", bus.health_value, 3);
    tick(n); chk("s2_health_r8", bus.health_value, 2);
    bus.heal_pulse = 1'b1; cyc();
    chk("s2_heal", bus.health_value, 3);

    // care saturation, care vs decay expiry, care restarting the decay period
    do_reset();
    bus.care_pulse = 4'b0010; cyc();
    chk("s3_care_sat", bus.need_values[5:3], 5);
    for (int t = 1; t <= 8; t++) begin
      tick(n);
      if (t == 6) chk("s3_need1_t6", bus.need_values[5:3], 3);
    end
    wait_sec(n);
    bus.care_pulse = 4'b0010; cyc();
    chk("s3_care_beats_decay", bus.need_values[5:3], 4);
    tick(n); chk("s3_need1_t10", bus.need_values[5:3], 4);
    bus.care_pulse = 4'b0010; cyc();
    chk("s3_care_inc", bus.need_values[5:3], 5);
    tick(n); tick(n);
    chk("s3_need1_t12", bus.need_values[5:3], 5);
    tick(n);
    chk("s3_need1_t13", bus.need_values[5:3], 4);
    chk("s3_health_t13", bus.health_value, 2);

    // TEST mode editing, frozen counters, health floor
    do_reset();
    bus.test_toggle = 1'b1; cyc();
    bus.test_next = 1'b1; cyc();
    bus.test_next = 1'b1; cyc();
    chk("s4_sel2", bus.test_sel, 2);
    for (int k = 0; k < 6; k++) begin bus.test_dec = 1'b1; cyc(); end
    chk("s4_need2_floor", bus.need_values, pack(16'h5055));
    bus.test_inc = 1'b1; cyc();
    bus.test_inc = 1'b1; cyc();
    bus.test_inc = 1'b1; bus.test_dec = 1'b1; cyc();
    chk("s4_inc_dec_both", bus.need_values[8:6], 2);
    for (int k = 0; k < 3; k++) begin bus.test_inc = 1'b1; cyc(); end
    chk("s4_need2_5", bus.need_values[8:6], 5);
    bus.test_inc = 1'b1; cyc();
    chk("s4_need2_sat", bus.need_values[8:6], 5);
    for (int t = 0; t < 20; t++) tick(n);
    chk("s4_frozen_needs", bus.need_values, pack(16'h5555));
    chk("s4_frozen_health", bus.health_value, 5);
    chk("s4_still_test", bus.test_mode, 1);
    bus.test_next = 1'b1; cyc();
    bus.test_next = 1'b1; cyc();
    chk("s4_sel4", bus.test_sel, 4);
    for (int k = 0; k < 10; k++) begin bus.test_dec = 1'b1; cyc(); end
    chk("s4_health_floor", bus.health_value, 1);
    chk("s4_alive", bus.alive, 1);
    bus.test_inc = 1'b1; cyc();
    chk("s4_health_inc", bus.health_value, 2);
    bus.test_next = 1'b1; cyc();
    chk("s4_sel_wrap", bus.test_sel, 0);
    bus.test_toggle = 1'b1; cyc();
    chk("s4_run_mode", bus.test_mode, 0);
    tick(n);
    chk("s4_resume_t1", bus.need_values, pack(16'h4555));
    chk("s4_resume_health", bus.health_value, 2);
    tick(n);
    chk("s4_resume_t2", bus.need_values, pack(16'h4455));

    // reset from inside TEST restores mode and staggered counters
    bus.test_toggle = 1'b1; cyc();
    bus.test_next = 1'b1; cyc();
    chk("s6_sel1", bus.test_sel, 1);
    do_reset();
    chk("s6_test_mode", bus.test_mode, 0);
    chk("s6_test_sel", bus.test_sel, 0);
    chk("s6_needs", bus.need_values, pack(16'h5555));
    chk("s6_health", bus.health_value, 5);
    tick(n); chk("s6_period", n, 4);
    chk("s6_t1", bus.need_values, pack(16'h4555));
    tick(n); chk("s6_t2", bus.need_values, pack(16'h4455));
    tick(n); chk("s6_t3", bus.need_values, pack(16'h4444));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pet_needs_engine.md
Name: pet_needs_engine

Overview:
Parametrised need/health engine for the Tamagotchi core. It generalises the fixed five-stat block to NUM_NEEDS independent need channels with configurable width, limits and decay periods. Health is shared and driven by the penalties from critical channels. The block sits between the debounced input/sensor pulses (feed, light, echo, heal) and the display/animation logic, and adds explicit RUN/TEST/DEAD modes with per-channel critical flags.

Parameters:
NUM_NEEDS, 4, number of need channels (feed, sleep, fun, happy...); range 1..8
VAL_W, 3, width of each stat value
VAL_MAX, 5, saturation ceiling for every stat (<= 2^VAL_W-1)
VAL_INIT, 5, reset value of every stat
TICK_DIV, 50000000, clk cycles per one-second tick
DECAY_PERIOD, 30, seconds between -1 decays of a need channel
CRIT_LEVEL, 2, a need is critical when 0 < value <= CRIT_LEVEL or value == 0
PENALTY_PERIOD, 10, critical-seconds accumulated before health -1
SEL_W, 3, width of test_sel; must satisfy 2^SEL_W > NUM_NEEDS

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
care_pulse  in  NUM_NEEDS  one-cycle care pulse per channel (bit i raises need i)
heal_pulse  in  1  one-cycle heal pulse
test_toggle  in  1  one-cycle pulse; enter/leave TEST
test_next  in  1  one-cycle pulse; advance test_sel
test_inc  in  1  one-cycle pulse; +1 on selected stat (TEST only)
test_dec  in  1  one-cycle pulse; -1 on selected stat (TEST only)
need_values  out  NUM_NEEDS*VAL_W  packed need values, channel i at [i*VAL_W +: VAL_W]
health_value  out  VAL_W  health
critical_mask  out  NUM_NEEDS  bit i = need i <= CRIT_LEVEL
sec_tick  out  1  one-cycle pulse each second
test_mode  out  1  1 in TEST
test_sel  out  SEL_W  selected stat; 0..NUM_NEEDS-1 = needs, NUM_NEEDS = health
alive  out  1  0 in DEAD

Behaviour:
- Reset (rst=1 at posedge clk):
  - all needs and health = VAL_INIT; mode RUN; alive=1; test_mode=0; test_sel=0; sec_tick=0; prescaler=0; penalty counter=0.
  - Decay counter i = (i*DECAY_PERIOD)/NUM_NEEDS, which staggers the channels.
  - Reset takes effect from any mode, including DEAD and mid-TEST.
- Prescaler: counts 0..TICK_DIV-1 and wraps. sec_tick=1 on the cycle following count==TICK_DIV-1. It runs in every mode.
- Mode FSM:
  - RUN -> TEST on test_toggle.
  - TEST -> RUN on test_toggle.
  - RUN or TEST -> DEAD when health becomes 0.
  - DEAD exits only via rst. test_toggle in DEAD is ignored.
- RUN, per need channel i, evaluated on each cycle:
  - care_pulse[i]: value = min(value+1, VAL_MAX); decay counter i cleared to 0.
  - Otherwise on sec_tick: the decay counter increments. On reaching DECAY_PERIOD-1 it wraps to 0 and value = max(value-1, 0).
  - care_pulse and decay expiry in the same cycle: care wins and the decay is discarded.
- RUN, health:
  - On sec_tick, if critical_mask != 0, the penalty counter increments.
  - At PENALTY_PERIOD-1 the penalty counter wraps and health -1 (penalty event).
  - If critical_mask == 0, the penalty counter holds.
  - heal_pulse: health = min(health+1, VAL_MAX).
  - heal_pulse and a penalty event in the same cycle: health unchanged.
- TEST:
  - Decay and penalty counters are frozen; care_pulse and heal_pulse are ignored.
  - test_sel clears to 0 on entry. test_next advances it and wraps NUM_NEEDS -> 0.
  - test_inc: +1 on the selected stat, saturating at VAL_MAX.
  - test_dec: -1 on the selected stat. Needs saturate at 0; health saturates at 1 (TEST cannot kill).
  - test_inc and test_dec together: no change.
  - On return to RUN, counters resume from their frozen values.
- DEAD: all needs and health forced to 0, critical_mask all 1, alive=0. All inputs except rst are ignored.
- Outputs:
  - All stat outputs, test_mode, test_sel, alive and sec_tick are registered. Latency is 1 cycle from input pulse to updated value.
  - critical_mask is combinational from the registered needs.
- All arithmetic is done at VAL_W+1 bits before saturation; no wrap-around is permitted.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, DECAY_PERIOD=3, PENALTY_PERIOD=2, NUM_NEEDS=4.
- Reset, then idle 12 sec_ticks -> need0 decays 5->4 after 3 ticks and 5->1 after 12. Channels decrement on staggered ticks (offsets 0,0,1,2 per formula). No underflow below 0.
- Hold need0 at 2 (critical), idle -> health -1 every 2 sec_ticks. Then pulse heal_pulse on the exact penalty cycle -> health unchanged.
- care_pulse[1] with need1=5 -> stays 5. care_pulse[1] coincident with decay expiry at value 3 -> 4 next cycle and decay counter=0.
- test_toggle, test_next x2, test_inc x3 on need2=2 -> need2=5. Idle 20 ticks -> no change. test_sel=4, test_dec x10 -> health=1, alive=1. test_next from 4 -> 0.
- Let health reach 0 in RUN -> next cycle alive=0 and all values 0. care, heal and test_toggle are ignored. rst=1 for one cycle -> all values 5, alive=1.
- Assert rst mid-TEST with frozen counters -> test_mode=0, test_sel=0, counters back to staggered initial values.
